// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl: per-frame pong ball sequencer with wall/paddle bounces, goals and serve timing
module ball_motion_ctrl #(
  parameter int SCREEN_WIDTH     = 640,
  parameter int SCREEN_HEIGHT    = 480,
  parameter int BALL_WIDTH       = 6,
  parameter int BALL_HEIGHT      = 8,
  parameter int PADDLE_WIDTH     = 8,
  parameter int PADDLE_HEIGHT    = 64,
  parameter int LEFT_PADDLE_COL  = 32,
  parameter int RIGHT_PADDLE_COL = 608,
  parameter int SPEED            = 2,
  parameter int SERVE_FRAMES     = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic [11:0] left_paddle_row,
  input  logic [11:0] right_paddle_row,
  output logic [11:0] ball_center_row,
  output logic [11:0] ball_center_col,
  output logic        serving,
  output logic        left_score,
  output logic        right_score
);
  localparam logic [11:0] CR      = 12'(SCREEN_HEIGHT / 2);
  localparam logic [11:0] CC      = 12'(SCREEN_WIDTH / 2);
  localparam logic [11:0] SP      = 12'(SPEED);
  localparam logic [11:0] BH2     = 12'(BALL_HEIGHT / 2);
  localparam logic [11:0] BW2     = 12'(BALL_WIDTH / 2);
  localparam logic [11:0] HMAX    = 12'(SCREEN_HEIGHT - 1);
  localparam logic [11:0] WMAX    = 12'(SCREEN_WIDTH - 1);
  localparam logic [11:0] ROW_MAX = 12'(SCREEN_HEIGHT - 1 - BALL_HEIGHT / 2);
  localparam logic [11:0] FACE_R  = 12'(RIGHT_PADDLE_COL - PADDLE_WIDTH / 2);
  localparam logic [11:0] FACE_L  = 12'(LEFT_PADDLE_COL + PADDLE_WIDTH / 2);
  localparam logic [11:0] OVL     = 12'((PADDLE_HEIGHT + BALL_HEIGHT) / 2);
  localparam logic [11:0] SF_LAST = 12'(SERVE_FRAMES - 1);
  typedef enum logic [1:0] {SERVE, PLAY, SCORED} state_t;
  state_t      state;
  logic [11:0] serve_cnt, dl, dr, next_row, next_col;
  logic        dir_right, dir_down, bot, top, hit_r, hit_l, goal_l, goal_r;
  logic        next_dir_down, next_dir_right;
  always_comb begin
    dl             = ball_center_row >= left_paddle_row ? ball_center_row - left_paddle_row : left_paddle_row - ball_center_row;
    dr             = ball_center_row >= right_paddle_row ? ball_center_row - right_paddle_row : right_paddle_row - ball_center_row;
    bot            = dir_down && (ball_center_row + SP + BH2 >= HMAX);
    top            = !dir_down && (ball_center_row < SP + BH2);
    next_row       = bot ? ROW_MAX : top ? BH2 : dir_down ? ball_center_row + SP : ball_center_row - SP;
    next_dir_down  = bot ? 1'b0 : top ? 1'b1 : dir_down;
    // left-side tests are rearranged so nothing is subtracted from col
    hit_r          = dir_right && (ball_center_col + BW2 < FACE_R) && (ball_center_col + SP + BW2 >= FACE_R) && (dr <= OVL);
    hit_l          = !dir_right && (ball_center_col > FACE_L + BW2) && (ball_center_col <= FACE_L + SP + BW2) && (dl <= OVL);
    goal_l         = dir_right && !hit_r && (ball_center_col + SP + BW2 >= WMAX);
    goal_r         = !dir_right && !hit_l && (ball_center_col < SP + BW2);
    next_col       = hit_r ? FACE_R - BW2 : hit_l ? FACE_L + BW2 : dir_right ? ball_center_col + SP : ball_center_col - SP;
    next_dir_right = hit_r ? 1'b0 : hit_l ? 1'b1 : dir_right;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= SERVE;
      serve_cnt       <= '0;
      ball_center_row <= CR;
      ball_center_col <= CC;
      dir_right       <= 1'b1;
      dir_down        <= 1'b1;
      serving         <= 1'b1;
      left_score      <= 1'b0;
      right_score     <= 1'b0;
    end else begin
      left_score  <= 1'b0;
      right_score <= 1'b0;
      case (state)
        SERVE: if (frame_tick) begin
          if (serve_cnt == SF_LAST) begin
            serve_cnt <= '0;
            state     <= PLAY;
            serving   <= 1'b0;
          end else serve_cnt <= serve_cnt + 12'd1;
        end
        PLAY: if (frame_tick) begin
          if (goal_l || goal_r) begin
            state       <= SCORED;
            left_score  <= goal_l;
            right_score <= goal_r;
          end else begin
            ball_center_row <= next_row;
            ball_center_col <= next_col;
            dir_down        <= next_dir_down;
            dir_right       <= next_dir_right;
          end
        end
        SCORED: begin
          state           <= SERVE;
          serving         <= 1'b1;
          serve_cnt       <= '0;
          ball_center_row <= CR;
          ball_center_col <= CC;
          dir_right       <= left_score;
          dir_down        <= !dir_down;
        end
        default: state <= SERVE;
      endcase
    end
  end
endmodule

// File: tb/tb_ball_motion_ctrl.sv
// tb_ball_motion_ctrl: random rally stimulus against a plain-integer model of the ball rules
module tb_ball_motion_ctrl;
  localparam int W = 640, H = 480, BW = 6, BH = 8, PW = 8, PH = 64;
  localparam int LPC = 32, RPC = 608, SPD = 2, SF = 60;
  logic        clk = 1'b0, reset, frame_tick;
  logic [11:0] left_paddle_row, right_paddle_row, ball_center_row, ball_center_col;
  logic        serving, left_score, right_score;
  int checks = 0, errors = 0;
  int m_row, m_col, m_dr, m_dd, m_st, m_cnt, m_ls, m_rs;
  int n_row, n_col, n_dr, n_dd, n_st, n_cnt, n_ls, n_rs;
  int goals_seen = 0, injected = 0;
  bit prev_tk = 0;
  ball_motion_ctrl dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .left_paddle_row(left_paddle_row), .right_paddle_row(right_paddle_row),
    .ball_center_row(ball_center_row), .ball_center_col(ball_center_col),
    .serving(serving), .left_score(left_score), .right_score(right_score)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int iabs(input int x);
    return x < 0 ? -x : x;
  endfunction
  // st: 0 = resting at centre, 1 = in play, 2 = goal cycle
  function automatic void model_next(input bit rst, input bit tk, input int lp, input int rp);
    int r, dd, c, dr;
    bit gl, gr;
    n_row = m_row; n_col = m_col; n_dr = m_dr; n_dd = m_dd;
    n_st = m_st; n_cnt = m_cnt; n_ls = 0; n_rs = 0;
    if (rst) begin
      n_row = H / 2; n_col = W / 2; n_dr = 1; n_dd = 1; n_st = 0; n_cnt = 0;
    end else if (m_st == 2) begin
      n_st = 0; n_row = H / 2; n_col = W / 2; n_cnt = 0; n_dr = m_ls; n_dd = !m_dd;
    end else if (m_st == 0 && tk) begin
      if (m_cnt == SF - 1) begin n_cnt = 0; n_st = 1; end
      else n_cnt = m_cnt + 1;
    end else if (m_st == 1 && tk) begin
      gl = 0; gr = 0;
      if (m_dd && m_row + SPD + BH / 2 >= H - 1) begin r = H - 1 - BH / 2; dd = 0; end
      else if (!m_dd && m_row - SPD - BH / 2 < 0) begin r = BH / 2; dd = 1; end
      else begin r = m_dd ? m_row + SPD : m_row - SPD; dd = m_dd; end
      c = m_col; dr = m_dr;
      if (m_dr) begin
        if (m_col + BW / 2 < RPC - PW / 2 && m_col + SPD + BW / 2 >= RPC - PW / 2 &&
            iabs(m_row - rp) <= (PH + BH) / 2) begin c = RPC - PW / 2 - BW / 2; dr = 0; end
        else if (m_col + SPD + BW / 2 >= W - 1) gl = 1;
        else c = m_col + SPD;
      end else begin
        if (m_col - BW / 2 > LPC + PW / 2 && m_col - SPD - BW / 2 <= LPC + PW / 2 &&
            iabs(m_row - lp) <= (PH + BH) / 2) begin c = LPC + PW / 2 + BW / 2; dr = 1; end
        else if (m_col - SPD - BW / 2 < 0) gr = 1;
        else c = m_col - SPD;
      end
      if (gl || gr) begin n_st = 2; n_ls = gl; n_rs = gr; end
      else begin n_row = r; n_col = c; n_dr = dr; n_dd = dd; end
    end
  endfunction
  task automatic step(input bit rst, input bit tk);
    reset = rst;
    frame_tick = tk;
    model_next(rst, tk, int'(left_paddle_row), int'(right_paddle_row));
    m_row = n_row; m_col = n_col; m_dr = n_dr; m_dd = n_dd;
    m_st = n_st; m_cnt = n_cnt; m_ls = n_ls; m_rs = n_rs;
    @(posedge clk);
    #1;
    check("row", ball_center_row, m_row);
    check("col", ball_center_col, m_col);
    check("serving", serving, m_st == 0);
    check("left_score", left_score, m_ls);
    check("right_score", right_score, m_rs);
  endtask
  function automatic logic [11:0] paddle_pos();
    int p;
    p = $urandom_range(0, 1) ? m_row + int'($urandom_range(0, 70)) - 35 : int'($urandom_range(0, H - 1));
    return 12'(p < 0 ? 0 : p > H - 1 ? H - 1 : p);
  endfunction
  initial begin
    bit rst, tk, inj;
    reset = 1'b1; frame_tick = 1'b0;
    left_paddle_row = 12'd240; right_paddle_row = 12'd240;
    step(1, 0);
    step(1, 1);
    check("reset_row", ball_center_row, 240);
    check("reset_col", ball_center_col, 320);
    check("reset_serving", serving, 1);
    for (int i = 0; i < SF - 1; i++) begin step(0, 1); step(0, 0); end
    check("serve59_serving", serving, 1);
    step(0, 1);
    check("serve60_serving", serving, 0);
    check("serve60_row", ball_center_row, 240);
    check("serve60_col", ball_center_col, 320);
    step(0, 0);
    step(0, 1);
    check("first_play_row", ball_center_row, 242);
    check("first_play_col", ball_center_col, 322);
    for (int i = 0; i < 16000; i++) begin
      left_paddle_row = paddle_pos();
      right_paddle_row = paddle_pos();
      tk = !prev_tk && ($urandom_range(0, 1) == 1);
      rst = ($urandom_range(0, 2999) == 0);
      inj = 0;
      if (!rst && tk) begin
        model_next(0, tk, int'(left_paddle_row), int'(right_paddle_row));
        if (n_ls || n_rs) begin
          goals_seen++;
          if (goals_seen % 3 == 2 && injected < 3) begin rst = 1; inj = 1; injected++; end
        end
      end
      step(rst, tk);
      prev_tk = tk;
      if (inj) begin
        check("rst_goal_left_score", left_score, 0);
        check("rst_goal_right_score", right_score, 0);
        check("rst_goal_col", ball_center_col, 320);
      end
    end
    check("goals_observed", goals_seen >= 4, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
